hawk_ped_request: RTL and testbench

Pedestrian push-button front end for the HAWK crosswalk. It sits directly upstream of the HAWK controller and drives its YP input. The block synchronises and debounces the raw button, then latches a single walk request. The request clears only when the controller reports the walk phase has started (W rising). It also keeps a saturating count of accepted presses for diagnostics.

---
 rtl/hawk_pkg.sv | 21 ++
 rtl/hawk_sync.sv | 31 +++
 rtl/hawk_ped_request.sv | 122 ++++++++++++
 tb/tb_hawk_ped_request.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hawk_pkg.sv
// Purpose : shared types and constants for the HAWK pedestrian-request front end.
// Latency : n/a (package).
// Backpressure: n/a (package).
package hawk_pkg;

  // Debounce FSM states: released, press pending, pressed, release pending.
  typedef enum logic [1:0] {
    REL    = 2'd0,
    P_WAIT = 2'd1,
    PRS    = 2'd2,
    R_WAIT = 2'd3
  } dbc_state_t;

  localparam logic [7:0] PRESS_CNT_MAX = 8'd255;

  // Saturating increment for the diagnostic press counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == PRESS_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hawk_sync.sv
// Purpose : plain flop-chain synchroniser for one asynchronous level input.
// Latency : SYNC_STAGES clk edges from d to q.
// Backpressure: none; the output tracks the input continuously.
//
// Ports: clk (clock), reset (async active-low), d (async input), q (synchronised output).
module hawk_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  import hawk_pkg::*;

  logic [SYNC_STAGES-1:0] chain;

  // Pure shift chain: nothing may sit between stages, or metastability
  // protection is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/hawk_ped_request.sv
// Purpose : push-button synchroniser + debouncer + single walk-request latch feeding HAWK YP.
// Latency : press_pulse after SYNC_STAGES+DEBOUNCE_CYC+1 edges of a held press; YP one edge later.
// Backpressure: none; a request is latched once and held until the walk phase starts.
//
// Ports: clk, reset (async active-low), btn_raw (async, bouncy), walk_active (HAWK W),
//        YP (latched request), btn_clean (debounced level), press_pulse (1-cycle strobe),
//        press_count (saturating accepted-press count).
module hawk_ped_request #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       walk_active,
  output logic       YP,
  output logic       btn_clean,
  output logic       press_pulse,
  output logic [7:0] press_count
);

  import hawk_pkg::*;

  localparam logic [CNT_W-1:0] DBC_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             btn_s;
  dbc_state_t       state, next_state;
  logic [CNT_W-1:0] dbc, dbc_nxt;
  logic             press_pulse_nxt;
  logic             btn_clean_nxt;
  logic             walk_d;
  logic             walk_rise;

  hawk_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_s)
  );

  // State register; the debounce outputs are registered alongside it so they
  // change on the same edge as the state they decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= REL;
      dbc         <= '0;
      press_pulse <= 1'b0;
      btn_clean   <= 1'b0;
    end else begin
      state       <= next_state;
      dbc         <= dbc_nxt;
      press_pulse <= press_pulse_nxt;
      btn_clean   <= btn_clean_nxt;
    end
  end

  // Next-state: a level must be seen on DEBOUNCE_CYC+1 consecutive samples
  // (the entry sample plus DEBOUNCE_CYC counted ones) before it is accepted.
  always_comb begin
    next_state = state;
    dbc_nxt    = dbc;
    case (state)
      REL: begin
        if (btn_s) begin
          next_state = P_WAIT;
          dbc_nxt    = '0;
        end
      end
      P_WAIT: begin
        if (!btn_s)               next_state = REL;
        else if (dbc == DBC_LAST) next_state = PRS;
        else                      dbc_nxt    = dbc + CNT_W'(1);
      end
      PRS: begin
        if (!btn_s) begin
          next_state = R_WAIT;
          dbc_nxt    = '0;
        end
      end
      R_WAIT: begin
        // Bounce during release returns to PRS silently: one pulse per hold.
        if (btn_s)                next_state = PRS;
        else if (dbc == DBC_LAST) next_state = REL;
        else                      dbc_nxt    = dbc + CNT_W'(1);
      end
      default: begin
        next_state = REL;
        dbc_nxt    = '0;
      end
    endcase
  end

  // Output decode on the transition, registered in the state process.
  always_comb begin
    press_pulse_nxt = (state == P_WAIT) && (next_state == PRS);
    btn_clean_nxt   = (next_state == PRS) || (next_state == R_WAIT);
  end

  assign walk_rise = walk_active & ~walk_d;

  // Request latch: the walk phase starting always wins over a new press, and
  // presses while the walk is already on are ignored (pedestrian is served).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      walk_d      <= 1'b0;
      YP          <= 1'b0;
      press_count <= 8'd0;
    end else begin
      walk_d <= walk_active;
      if (walk_rise) begin
        YP <= 1'b0;
      end else if (press_pulse && !walk_active) begin
        YP          <= 1'b1;
        press_count <= sat_inc(press_count);
      end
    end
  end

endmodule

// File: tb/tb_hawk_ped_request.sv
module tb_hawk_ped_request;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_raw = 1'b0;
  logic       walk_active = 1'b0;
  logic       YP;
  logic       btn_clean;
  logic       press_pulse;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;

  hawk_ped_request #(
    .SYNC_STAGES (S),
    .DEBOUNCE_CYC(D),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .walk_active(walk_active),
    .YP         (YP),
    .btn_clean  (btn_clean),
    .press_pulse(press_pulse),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Synchroniser = pure delay of S samples (queue). Debounce = run length of
  // samples differing from the accepted level; D+1 in a row flips the level.
  bit       m_pipe[$];
  bit       m_clean, m_pulse, m_yp, m_walk_prev, m_bs, m_pulse_now;
  int       m_run;
  int       m_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pipe = {};
      for (int i = 0; i < S; i++) m_pipe.push_back(1'b0);
      m_clean = 0; m_pulse = 0; m_yp = 0; m_walk_prev = 0; m_run = 0; m_cnt = 0;
    end else begin
      if (walk_active && !m_walk_prev) m_yp = 0;
      else if (m_pulse && !walk_active) begin
        m_yp = 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
      m_walk_prev = walk_active;
      m_bs = m_pipe[0];
      m_pulse_now = 0;
      if (m_bs != m_clean) begin
        m_run = m_run + 1;
        if (m_run == D + 1) begin
          m_clean = m_bs;
          m_run = 0;
          m_pulse_now = m_bs;
        end
      end else begin
        m_run = 0;
      end
      m_pulse = m_pulse_now;
      void'(m_pipe.pop_front());
      m_pipe.push_back(btn_raw);
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_yp",    YP,          m_yp);
    chk("cmp_clean", btn_clean,   m_clean);
    chk("cmp_pulse", press_pulse, m_pulse);
    chk("cmp_count", press_count, m_cnt);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_press(input int hold);
    @(negedge clk) btn_raw = 1'b1;
    repeat (hold) @(negedge clk);
    btn_raw = 1'b0;
    repeat (S + D + 3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [7:0] c0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_yp", YP, 0);
    chk("rst_count", press_count, 0);
    chk("rst_clean", btn_clean, 0);
    chk("rst_pulse", press_pulse, 0);

    // 1. Held press: pulse after edge 7, YP after edge 8, clean from edge 7.
    @(negedge clk);
    reset = 1'b1;
    btn_raw = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      chk($sformatf("t1_pulse_e%0d", e), press_pulse, (e == 7) ? 1 : 0);
      chk($sformatf("t1_clean_e%0d", e), btn_clean,   (e >= 7) ? 1 : 0);
      chk($sformatf("t1_yp_e%0d", e),    YP,          (e >= 8) ? 1 : 0);
      chk($sformatf("t1_cnt_e%0d", e),   press_count, (e >= 8) ? 1 : 0);
    end
    repeat (5) @(negedge clk);
    btn_raw = 1'b0;
    repeat (S + D + 4) @(negedge clk);

    // 2. Bounce 1,0,1,0 every 2 cycles then settle low: rejected.
    c0 = press_count;
    for (int k = 0; k < 4; k++) begin
      btn_raw = (k % 2 == 0);
      repeat (2) @(negedge clk);
    end
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    chk("t2_count", press_count, c0);
    chk("t2_clean", btn_clean, 0);
    chk("t2_yp", YP, 1);

    // 3. Walk rise clears YP; press during walk ignored; walk fall no effect.
    walk_active = 1'b1;
    @(posedge clk); #1;
    chk("t3_yp_clear", YP, 0);
    c0 = press_count;
    do_press(S + D + 3);
    chk("t3_yp_walk", YP, 0);
    chk("t3_cnt_walk", press_count, c0);
    walk_active = 1'b0;
    repeat (5) @(negedge clk);
    chk("t3_yp_fall", YP, 0);

    // 4. press_pulse and walk_rise in the same cycle.
    do_press(S + D + 3);
    chk("t4_yp_pre", YP, 1);
    c0 = press_count;
    @(negedge clk) btn_raw = 1'b1;
    repeat (7) @(posedge clk);
    #1 chk("t4_pulse", press_pulse, 1);
    @(negedge clk) walk_active = 1'b1;
    @(posedge clk); #1;
    chk("t4_yp", YP, 0);
    chk("t4_cnt", press_count, c0);
    @(negedge clk) btn_raw = 1'b0;
    repeat (S + D + 4) @(negedge clk);

    // Randomized phase, checked by the model every cycle.
    for (int it = 0; it < 150; it++) begin
      btn_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) walk_active = ~walk_active;
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    btn_raw = 1'b0;
    walk_active = 1'b0;
    repeat (S + D + 4) @(negedge clk);

    // 5. 260 clean presses: count saturates, YP stays set.
    for (int p = 0; p < 260; p++) begin
      do_press(S + D + 3);
      if (p == 0 || p == 259) chk($sformatf("t5_yp_p%0d", p), YP, 1);
    end
    chk("t5_cnt_sat", press_count, 255);

    // 6. Async reset mid-P_WAIT with YP=1.
    @(negedge clk) btn_raw = 1'b1;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_yp_rst", YP, 0);
    chk("t6_cnt_rst", press_count, 0);
    chk("t6_clean_rst", btn_clean, 0);
    chk("t6_pulse_rst", press_pulse, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      chk($sformatf("t6_yp_e%0d", e),    YP,          (e >= 8) ? 1 : 0);
      chk($sformatf("t6_pulse_e%0d", e), press_pulse, (e == 7) ? 1 : 0);
    end
    chk("t6_cnt", press_count, 1);
    @(negedge clk) btn_raw = 1'b0;
    repeat (S + D + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
